// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter.
// Holds the arbiter state encoding, the request bundle and the owner-select mux.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_G0,
    ARB_G1
  } arb_state_t;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  // Selects the owner's request fields; no owner yields an all-zero request.
  function automatic wb_req_t req_mux(input logic [1:0] grant,
                                      input wb_req_t   r0,
                                      input wb_req_t   r1);
    case (grant)
      2'b01:   return r0;
      2'b10:   return r1;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/if_wb.sv
// Classic Wishbone bus bundle with master and slave views.
// Write data is dat_w (master to slave), read data is dat_r (slave to master).
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter with cycle-granularity locking.
// Optional slave watchdog compiled in with WB_ARB_TIMEOUT_EN.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = 1023,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  if_wb.slave        m0,
  if_wb.slave        m1,
  if_wb.master       s,
  output logic [1:0] grant,
  output logic       timeout
);

  arb_state_t  state_reg;
  logic        last_reg;
  wb_req_t     req0;
  wb_req_t     req1;
  wb_req_t     own;
  logic        wd_fire;
  logic        own_ack;
  logic [31:0] own_dat;

  // last_reg names the master that owned the bus most recently; ties go to the other.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ARB_IDLE;
      last_reg  <= 1'b1;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (m0.cyc && m1.cyc)
            state_reg <= last_reg ? ARB_G0 : ARB_G1;
          else if (m0.cyc)
            state_reg <= ARB_G0;
          else if (m1.cyc)
            state_reg <= ARB_G1;
        end
        ARB_G0: begin
          if (!m0.cyc) begin
            last_reg  <= 1'b0;
            state_reg <= m1.cyc ? ARB_G1 : ARB_IDLE;
          end
        end
        ARB_G1: begin
          if (!m1.cyc) begin
            last_reg  <= 1'b1;
            state_reg <= m0.cyc ? ARB_G0 : ARB_IDLE;
          end
        end
        default: state_reg <= ARB_IDLE;
      endcase
    end
  end

  assign grant = {state_reg == ARB_G1, state_reg == ARB_G0};

  assign req0 = '{cyc: m0.cyc, stb: m0.stb, we: m0.we, sel: m0.sel, adr: m0.adr, dat: m0.dat_w};
  assign req1 = '{cyc: m1.cyc, stb: m1.stb, we: m1.we, sel: m1.sel, adr: m1.adr, dat: m1.dat_w};
  assign own  = req_mux(grant, req0, req1);

`ifdef WB_ARB_TIMEOUT_EN
  logic [TW-1:0] wd_cnt_reg;
  logic          grant_change;

  always_comb begin
    grant_change = 1'b0;
    case (state_reg)
      ARB_IDLE: grant_change = m0.cyc | m1.cyc;
      ARB_G0:   grant_change = ~m0.cyc;
      ARB_G1:   grant_change = ~m1.cyc;
      default:  grant_change = 1'b1;
    endcase
  end

  // Fires on the TIMEOUT-th consecutive cycle of an unacknowledged strobe.
  assign wd_fire = own.stb && !s.ack && (wd_cnt_reg == TW'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || grant_change || s.ack || !own.stb || wd_fire)
      wd_cnt_reg <= '0;
    else
      wd_cnt_reg <= wd_cnt_reg + TW'(1);
  end
`else
  logic [TW-1:0] unused_cfg;

  assign unused_cfg = TW'(TIMEOUT);
  assign wd_fire    = 1'b0;
`endif

  assign timeout = wd_fire;

  assign s.cyc   = own.cyc & ~wd_fire;
  assign s.stb   = own.stb & ~wd_fire;
  assign s.we    = own.we;
  assign s.sel   = own.sel;
  assign s.adr   = own.adr;
  assign s.dat_w = own.dat;

  // A stray ack without an active strobe is not forwarded.
  assign own_ack = wd_fire | (s.ack & own.stb);
  assign own_dat = wd_fire ? TIMEOUT_DATA : s.dat_r;

  always_comb begin
    m0.ack   = grant[0] & own_ack;
    m0.dat_r = grant[0] ? own_dat : 32'h0;
    m1.ack   = grant[1] & own_ack;
    m1.dat_r = grant[1] ? own_dat : 32'h0;
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed testbench for wb_arbiter2: arbitration, locking, handoff, reset, watchdog.
// Watchdog expectations follow WB_ARB_TIMEOUT_EN as seen by this compile.
module tb_wb_arbiter2;
  import wb_arb_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [1:0] grant;
  logic       timeout;

  if_wb m0_if ();
  if_wb m1_if ();
  if_wb s_if ();

  wb_arbiter2 #(.TIMEOUT(16)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .m0      (m0_if),
    .m1      (m1_if),
    .s       (s_if),
    .grant   (grant),
    .timeout (timeout)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_m0(input logic cyc, input logic stb, input logic [31:0] adr);
    m0_if.cyc = cyc; m0_if.stb = stb; m0_if.adr = adr;
  endtask

  task automatic drive_m1(input logic cyc, input logic stb, input logic [31:0] adr);
    m1_if.cyc = cyc; m1_if.stb = stb; m1_if.adr = adr;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive_m0(1'b0, 1'b0, 32'h0); m0_if.we = 1'b0; m0_if.sel = 4'hF; m0_if.dat_w = 32'hA0A0A0A0;
    drive_m1(1'b0, 1'b0, 32'h0); m1_if.we = 1'b0; m1_if.sel = 4'hF; m1_if.dat_w = 32'hB1B1B1B1;
    s_if.ack = 1'b1; s_if.dat_r = 32'hCAFEF00D;
    tick(); tick();
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
    checks++; if (s_if.cyc !== 1'b0 || s_if.stb !== 1'b0) begin errors++; $display("FAIL reset_s_cyc_stb: got %b%b expected 00", s_if.cyc, s_if.stb); end
    checks++; if (s_if.adr !== 32'h0 || s_if.dat_w !== 32'h0) begin errors++; $display("FAIL reset_s_adr_dat: got %h/%h expected 0/0", s_if.adr, s_if.dat_w); end
    checks++; if (m0_if.ack !== 1'b0 || m1_if.ack !== 1'b0) begin errors++; $display("FAIL reset_acks: got %b%b expected 00", m1_if.ack, m0_if.ack); end
    checks++; if (m0_if.dat_r !== 32'h0 || m1_if.dat_r !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", m0_if.dat_r, m1_if.dat_r); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    $display("reset: grant=%b s.cyc=%b", grant, s_if.cyc);
    rst_i = 1'b0; s_if.ack = 1'b0;
    tick();
  endtask

  task automatic test_arbitration();
    drive_m0(1'b1, 1'b1, 32'h100);
    drive_m1(1'b1, 1'b1, 32'h200);
    #1;
    checks++; if (grant !== 2'b00 || s_if.cyc !== 1'b0) begin errors++; $display("FAIL arb_latency: got grant=%b cyc=%b expected 00/0", grant, s_if.cyc); end
    tick(); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL arb_first_tie: got %b expected 01", grant); end
    checks++; if (s_if.adr !== 32'h100 || s_if.cyc !== 1'b1) begin errors++; $display("FAIL arb_s_adr: got %h cyc=%b expected 100/1", s_if.adr, s_if.cyc); end
    checks++; if (m1_if.ack !== 1'b0) begin errors++; $display("FAIL arb_m1_noack: got %b expected 0", m1_if.ack); end
    $display("arbitration: grant=%b s.adr=%h", grant, s_if.adr);
  endtask

  task automatic test_lock();
    for (int beat = 0; beat < 3; beat++) begin
      m0_if.adr = 32'h100 + 32'(beat * 4);
      s_if.ack = 1'b0;
      #1;
      checks++; if (m0_if.ack !== 1'b0) begin errors++; $display("FAIL lock_wait%0d: got ack=%b expected 0", beat, m0_if.ack); end
      tick();
      s_if.ack = 1'b1; s_if.dat_r = 32'h1000 + 32'(beat);
      #1;
      checks++; if (m0_if.ack !== 1'b1 || m0_if.dat_r !== 32'h1000 + 32'(beat)) begin errors++; $display("FAIL lock_ack%0d: got ack=%b dat=%h expected 1/%h", beat, m0_if.ack, m0_if.dat_r, 32'h1000 + 32'(beat)); end
      checks++; if (m1_if.ack !== 1'b0 || grant !== 2'b01) begin errors++; $display("FAIL lock_hold%0d: got m1.ack=%b grant=%b expected 0/01", beat, m1_if.ack, grant); end
      $display("lock beat %0d: adr=%h m0.ack=%b grant=%b", beat, s_if.adr, m0_if.ack, grant);
      tick();
    end
    s_if.ack = 1'b0;
  endtask

  task automatic test_handoff();
    drive_m0(1'b0, 1'b0, 32'h0);
    #1;
    checks++; if (grant !== 2'b01 || s_if.cyc !== 1'b0) begin errors++; $display("FAIL handoff_drop: got grant=%b cyc=%b expected 01/0", grant, s_if.cyc); end
    tick(); #1;
    checks++; if (grant !== 2'b10 || s_if.adr !== 32'h200) begin errors++; $display("FAIL handoff_direct: got grant=%b adr=%h expected 10/200", grant, s_if.adr); end
    s_if.dat_r = 32'h12345678; s_if.ack = 1'b1;
    #1;
    checks++; if (m1_if.ack !== 1'b1 || m1_if.dat_r !== 32'h12345678) begin errors++; $display("FAIL m1_read: got ack=%b dat=%h expected 1/12345678", m1_if.ack, m1_if.dat_r); end
    checks++; if (m0_if.ack !== 1'b0 || m0_if.dat_r !== 32'h0) begin errors++; $display("FAIL m0_isolated: got ack=%b dat=%h expected 0/0", m0_if.ack, m0_if.dat_r); end
    $display("handoff read: grant=%b m1.dat=%h", grant, m1_if.dat_r);
    tick();
    s_if.ack = 1'b0;
    drive_m1(1'b0, 1'b0, 32'h0);
    tick(); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL both_drop_idle: got %b expected 00", grant); end
    drive_m0(1'b1, 1'b1, 32'h110);
    drive_m1(1'b1, 1'b1, 32'h210);
    tick(); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rr_after_m1: got %b expected 01", grant); end
    drive_m0(1'b0, 1'b0, 32'h0);
    drive_m1(1'b0, 1'b0, 32'h0);
    tick();
    drive_m0(1'b1, 1'b1, 32'h120);
    drive_m1(1'b1, 1'b1, 32'h220);
    tick(); #1;
    checks++; if (grant !== 2'b10 || s_if.adr !== 32'h220) begin errors++; $display("FAIL rr_after_m0: got grant=%b adr=%h expected 10/220", grant, s_if.adr); end
    $display("round-robin: grant=%b", grant);
  endtask

  task automatic test_ack_ignored();
    m1_if.stb = 1'b0; s_if.ack = 1'b1;
    #1;
    checks++; if (m1_if.ack !== 1'b0) begin errors++; $display("FAIL ack_no_stb: got %b expected 0", m1_if.ack); end
    m1_if.stb = 1'b1; s_if.ack = 1'b0;
    #1;
    checks++; if (s_if.stb !== 1'b1) begin errors++; $display("FAIL stb_restore: got %b expected 1", s_if.stb); end
    $display("ack without stb: m1.ack=%b", m1_if.ack);
  endtask

  task automatic test_reset_mid();
    rst_i = 1'b1;
    tick();
    s_if.ack = 1'b1;
    #1;
    checks++; if (grant !== 2'b00 || s_if.cyc !== 1'b0) begin errors++; $display("FAIL midrst_idle: got grant=%b cyc=%b expected 00/0", grant, s_if.cyc); end
    checks++; if (m0_if.ack !== 1'b0 || m1_if.ack !== 1'b0) begin errors++; $display("FAIL midrst_acks: got %b%b expected 00", m1_if.ack, m0_if.ack); end
    rst_i = 1'b0; s_if.ack = 1'b0;
    tick(); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL midrst_tie: got %b expected 01", grant); end
    $display("reset mid-transfer: grant=%b", grant);
    drive_m0(1'b0, 1'b0, 32'h0);
    drive_m1(1'b0, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_timeout();
    drive_m0(1'b1, 1'b1, 32'h300);
    s_if.ack = 1'b0; s_if.dat_r = 32'h0;
    tick();
    for (int k = 1; k <= 16; k++) begin
      #1;
`ifdef WB_ARB_TIMEOUT_EN
      if (k == 16) begin
        checks++; if (timeout !== 1'b1 || s_if.stb !== 1'b0 || s_if.cyc !== 1'b0) begin errors++; $display("FAIL wd_fire: got timeout=%b stb=%b cyc=%b expected 1/0/0", timeout, s_if.stb, s_if.cyc); end
        checks++; if (m0_if.ack !== 1'b1 || m0_if.dat_r !== 32'hDEADBEEF) begin errors++; $display("FAIL wd_ack: got ack=%b dat=%h expected 1/deadbeef", m0_if.ack, m0_if.dat_r); end
      end else begin
        checks++; if (timeout !== 1'b0 || s_if.stb !== 1'b1) begin errors++; $display("FAIL wd_stall%0d: got timeout=%b stb=%b expected 0/1", k, timeout, s_if.stb); end
      end
`else
      checks++; if (timeout !== 1'b0 || m0_if.ack !== 1'b0 || s_if.stb !== 1'b1) begin errors++; $display("FAIL hang%0d: got timeout=%b ack=%b stb=%b expected 0/0/1", k, timeout, m0_if.ack, s_if.stb); end
`endif
      tick();
    end
    #1;
    checks++; if (timeout !== 1'b0 || s_if.stb !== 1'b1 || grant !== 2'b01) begin errors++; $display("FAIL wd_after: got timeout=%b stb=%b grant=%b expected 0/1/01", timeout, s_if.stb, grant); end
    $display("watchdog: timeout=%b grant=%b", timeout, grant);
    drive_m0(1'b0, 1'b0, 32'h0);
    tick();
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_lock();
    test_handoff();
    test_ack_ignored();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
